serv_alu_ser: RTL

SERV_ALU_SER -- requirements
Module: serv_alu_ser

---
 rtl/serv_alu_ser.sv | 132 +++++++++++++
 1 files changed

// File: rtl/serv_alu_ser.sv
// serv_alu_ser -- word-to-serial adapter around a W-bit serial ALU.
//
// Accepts a pair of 32-bit operand words, feeds them to the ALU W bits
// per cycle (LSB chunk first) over N = 32/W beats, and assembles the
// returned W-bit result chunks into a 32-bit result word.
//
// Parameters:
//   W            ALU datapath width (1, 2, 4, 8, 16 or 32).
// Ports:
//   clk          clock; all state changes on the rising edge
//   i_rst        synchronous active-high reset
//   i_valid      operand word pair offered (sampled in IDLE only)
//   o_ready      block is idle and accepts an operand pair
//   i_rs1/i_op_b 32-bit operand words
//   o_en         serial beat active (ALU i_en)
//   o_cnt0       first beat of the word (ALU i_cnt0)
//   o_rs1/o_op_b W-bit operand chunks to the ALU, zero when o_en=0
//   i_rd         W-bit result chunk from the ALU, same cycle
//   i_cmp        ALU compare flag
//   o_res_valid  assembled result available
//   i_res_ready  consumer takes the result (sampled in DONE only)
//   o_res        assembled 32-bit result
//   o_res_cmp    compare flag captured on the final beat
// Configuration:
//   SERV_ALU_SER_CMP_EN  when defined, o_res_cmp captures i_cmp on beat N-1;
//                        otherwise o_res_cmp is tied to 0 and i_cmp is unused.
module serv_alu_ser #(
  parameter int unsigned W = 4
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [31:0]   i_rs1,
  input  logic [31:0]   i_op_b,
  output logic          o_en,
  output logic          o_cnt0,
  output logic [W-1:0]  o_rs1,
  output logic [W-1:0]  o_op_b,
  input  logic [W-1:0]  i_rd,
  input  logic          i_cmp,
  output logic          o_res_valid,
  input  logic          i_res_ready,
  output logic [31:0]   o_res,
  output logic          o_res_cmp
);

  localparam int unsigned N  = 32 / W;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [31:0]     rs1_sr, opb_sr, res_q;
  logic            last_beat;
  logic [W+31:0]   res_cat;

  assign last_beat = (cnt_q == CW'(N - 1));
  // {i_rd, res} shifted right by W leaves {i_rd, res[31:W]} in the low
  // 32 bits; this form stays legal when W = 32.
  assign res_cat   = {i_rd, res_q} >> W;

  always_ff @(posedge clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_valid)     state_d = RUN;
      RUN:     if (last_beat)   state_d = DONE;
      DONE:    if (i_res_ready) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      cnt_q  <= '0;
      rs1_sr <= '0;
      opb_sr <= '0;
      res_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_valid) begin
            rs1_sr <= i_rs1;
            opb_sr <= i_op_b;
            cnt_q  <= '0;
          end
        end
        RUN: begin
          rs1_sr <= rs1_sr >> W;
          opb_sr <= opb_sr >> W;
          res_q  <= res_cat[31:0];
          cnt_q  <= last_beat ? '0 : cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SERV_ALU_SER_CMP_EN
  logic cmp_q;

  always_ff @(posedge clk) begin
    if (i_rst)                            cmp_q <= 1'b0;
    else if (state_q == RUN && last_beat) cmp_q <= i_cmp;
  end

  assign o_res_cmp = cmp_q;
`else
  logic unused_cmp;
  assign unused_cmp = i_cmp;
  assign o_res_cmp  = 1'b0;
`endif

  assign o_ready     = (state_q == IDLE);
  assign o_en        = (state_q == RUN);
  assign o_res_valid = (state_q == DONE);
  assign o_cnt0      = o_en && (cnt_q == '0);
  assign o_rs1       = o_en ? rs1_sr[W-1:0] : '0;
  assign o_op_b      = o_en ? opb_sr[W-1:0] : '0;
  assign o_res       = res_q;

endmodule
